// File: rtl/posit_decode_sched_if.sv
// Request, decode-core and result signals of posit_decode_sched.
// slave is the scheduler side; master is the environment (requesters, core, sink).
interface posit_decode_sched_if #(
   parameter int unsigned N  = 64,
   parameter int unsigned ES = 4,
   parameter int unsigned RS = 7,
   parameter int unsigned FS = N - ES - 3
);
   logic          req0_valid;
   logic          req1_valid;
   logic [N-1:0]  req0_data;
   logic [N-1:0]  req1_data;
   logic          req0_ready;
   logic          req1_ready;
   logic [N-2:0]  dec_in;
   logic [RS-1:0] dec_regi;
   logic [ES-1:0] dec_expo;
   logic [FS-1:0] dec_frac;
   logic          out_valid;
   logic          out_ready;
   logic          out_tag;
   logic          out_sign;
   logic          out_zero;
   logic          out_nar;
   logic [RS-1:0] out_regi;
   logic [ES-1:0] out_expo;
   logic [FS-1:0] out_frac;
   logic [15:0]   grant_cnt0;
   logic [15:0]   grant_cnt1;

   modport slave (
      input  req0_valid, req1_valid, req0_data, req1_data,
      output req0_ready, req1_ready,
      output dec_in,
      input  dec_regi, dec_expo, dec_frac,
      output out_valid,
      input  out_ready,
      output out_tag, out_sign, out_zero, out_nar, out_regi, out_expo, out_frac,
      output grant_cnt0, grant_cnt1
   );

   modport master (
      output req0_valid, req1_valid, req0_data, req1_data,
      input  req0_ready, req1_ready,
      input  dec_in,
      output dec_regi, dec_expo, dec_frac,
      input  out_valid,
      output out_ready,
      input  out_tag, out_sign, out_zero, out_nar, out_regi, out_expo, out_frac,
      input  grant_cnt0, grant_cnt1
   );
endinterface

// File: rtl/posit_decode_sched.sv
// Two-requester round-robin front end for a shared combinational posit decode core.
// S1 holds the sign-stripped magnitude feeding the core; S2 registers the core result.
module posit_decode_sched #(
   parameter int unsigned N  = 64,
   parameter int unsigned ES = 4,
   parameter int unsigned RS = 7,
   parameter int unsigned FS = N - ES - 3
) (
   input logic                 clk,
   input logic                 rst_n,
   posit_decode_sched_if.slave bus
);
   localparam logic [N-1:0] NarWord = {1'b1, {(N-1){1'b0}}};

   logic          s1_valid, s1_tag, s1_sign, s1_zero, s1_nar;
   logic [N-2:0]  s1_mag;
   logic          s2_valid, s2_tag, s2_sign, s2_zero, s2_nar;
   logic [RS-1:0] s2_regi;
   logic [ES-1:0] s2_expo;
   logic [FS-1:0] s2_frac;
   logic          last_grant;
   logic [15:0]   cnt0, cnt1;

   logic          advance, accept_ok, grant0, grant1, take0, take1, take, special;
   logic [N-1:0]  sel_data, sel_neg;

   always_comb begin
      advance   = s1_valid && (!s2_valid || bus.out_ready);
      // rst_n gates the readies so nothing is offered while reset is held
      accept_ok = rst_n && (!s1_valid || advance);
      grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
      grant1    = bus.req1_valid && !grant0;
      take0     = grant0 && accept_ok;
      take1     = grant1 && accept_ok;
      take      = take0 || take1;
      sel_data  = take1 ? bus.req1_data : bus.req0_data;
      sel_neg   = -sel_data;
      special   = s1_zero || s1_nar;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_tag   <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_mag   <= '0;
      end else if (take) begin
         s1_valid <= 1'b1;
         s1_tag   <= take1;
         s1_sign  <= sel_data[N-1];
         s1_zero  <= (sel_data == '0);
         s1_nar   <= (sel_data == NarWord);
         s1_mag   <= sel_data[N-1] ? sel_neg[N-2:0] : sel_data[N-2:0];
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_tag   <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b0;
         s2_nar   <= 1'b0;
         s2_regi  <= '0;
         s2_expo  <= '0;
         s2_frac  <= '0;
      end else if (advance) begin
         s2_valid <= 1'b1;
         s2_tag   <= s1_tag;
         s2_sign  <= s1_sign && !special;
         s2_zero  <= s1_zero;
         s2_nar   <= s1_nar;
         s2_regi  <= special ? '0 : bus.dec_regi;
         s2_expo  <= special ? '0 : bus.dec_expo;
         s2_frac  <= special ? '0 : bus.dec_frac;
      end else if (bus.out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         cnt0       <= '0;
         cnt1       <= '0;
      end else begin
         if (take) last_grant <= take1;
         if (take0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if (take1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end

   assign bus.req0_ready = take0;
   assign bus.req1_ready = take1;
   assign bus.dec_in     = s1_valid ? s1_mag : '0;
   assign bus.out_valid  = s2_valid;
   assign bus.out_tag    = s2_tag;
   assign bus.out_sign   = s2_sign;
   assign bus.out_zero   = s2_zero;
   assign bus.out_nar    = s2_nar;
   assign bus.out_regi   = s2_regi;
   assign bus.out_expo   = s2_expo;
   assign bus.out_frac   = s2_frac;
   assign bus.grant_cnt0 = cnt0;
   assign bus.grant_cnt1 = cnt1;
endmodule

// File: tb/tb_posit_decode_sched.sv
// Bench for posit_decode_sched: a stub decode core plus a queue model of the two-slot pipeline.
module tb_posit_decode_sched;
   localparam int N  = 64;
   localparam int ES = 4;
   localparam int RS = 7;
   localparam int FS = N - ES - 3;
   localparam int W  = RS + ES + FS;
   localparam logic [N-1:0] Nar = {1'b1, {(N-1){1'b0}}};

   typedef struct {
      logic          tag, sign, zero, nar;
      logic [RS-1:0] regi;
      logic [ES-1:0] expo;
      logic [FS-1:0] frac;
      logic [N-2:0]  mag;
      int unsigned   acc;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   posit_decode_sched_if #(.N(N), .ES(ES), .RS(RS), .FS(FS)) bus ();

   posit_decode_sched #(.N(N), .ES(ES), .RS(RS), .FS(FS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Arbitrary deterministic stand-in for the decode core; non-zero even for a zero input.
   function automatic logic [W-1:0] core_f(input logic [N-2:0] m);
      return {m, 5'h16} ^ {m[4:0], m};
   endfunction

   assign {bus.dec_regi, bus.dec_expo, bus.dec_frac} = core_f(bus.dec_in);

   ent_t        q[$];
   int unsigned cyc;
   logic        last_g;
   int unsigned cnt0, cnt1;
   int          vectors, miscompares;
   logic        obs_r1;
   int          obs_acc;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic ent_t mk_ent(input logic tag, input logic [N-1:0] d);
      ent_t e;
      logic [N-1:0] m;
      e.tag  = tag;
      e.zero = (d == '0);
      e.nar  = (d == Nar);
      m      = d[N-1] ? (~d + 1'b1) : d;
      e.mag  = m[N-2:0];
      e.acc  = 0;
      if (e.zero || e.nar) begin
         e.sign = 1'b0; e.regi = '0; e.expo = '0; e.frac = '0;
      end else begin
         e.sign = d[N-1];
         {e.regi, e.expo, e.frac} = core_f(e.mag);
      end
      return e;
   endfunction

   function automatic logic [N-1:0] rnd_data();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return Nar;
         2:       return 64'hC000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Called just after a rising edge with inputs already driven; checks at the falling edge.
   task automatic step();
      logic exp_r0, exp_r1, g0, acc_ok, exp_ov;
      logic [N-2:0] exp_dec;
      ent_t e;
      @(negedge clk);
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (rst_n) begin
         g0     = bus.req0_valid && (!bus.req1_valid || last_g);
         acc_ok = (q.size() < 2) || bus.out_ready;
         exp_r0 = g0 && acc_ok;
         exp_r1 = bus.req1_valid && !g0 && acc_ok;
      end
      exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
      exp_dec = '0;
      if (q.size() == 2) exp_dec = q[1].mag;
      else if (q.size() == 1 && (cyc - q[0].acc) == 1) exp_dec = q[0].mag;
      chk("req0_ready", bus.req0_ready, exp_r0);
      chk("req1_ready", bus.req1_ready, exp_r1);
      chk("dec_in", bus.dec_in, exp_dec);
      chk("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
         chk("out_tag", bus.out_tag, q[0].tag);
         chk("out_sign", bus.out_sign, q[0].sign);
         chk("out_zero", bus.out_zero, q[0].zero);
         chk("out_nar", bus.out_nar, q[0].nar);
         chk("out_regi", bus.out_regi, q[0].regi);
         chk("out_expo", bus.out_expo, q[0].expo);
         chk("out_frac", bus.out_frac, q[0].frac);
      end
      chk("grant_cnt0", bus.grant_cnt0, cnt0[15:0]);
      chk("grant_cnt1", bus.grant_cnt1, cnt1[15:0]);
      obs_r1 = bus.req1_ready;
      if (bus.req0_ready || bus.req1_ready) obs_acc++;
      if (exp_ov && bus.out_ready) void'(q.pop_front());
      if (exp_r0 || exp_r1) begin
         e     = mk_ent(exp_r1, exp_r1 ? bus.req1_data : bus.req0_data);
         e.acc = cyc;
         q.push_back(e);
         last_g = exp_r1;
         if (exp_r0 && cnt0 < 16'hFFFF) cnt0++;
         if (exp_r1 && cnt1 < 16'hFFFF) cnt1++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_out_cleared(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_fields"},
          {bus.out_tag, bus.out_sign, bus.out_zero, bus.out_nar,
           bus.out_regi, bus.out_expo, bus.out_frac}, '0);
      chk({tag, "_cnt0"}, bus.grant_cnt0, 16'd0);
      chk({tag, "_cnt1"}, bus.grant_cnt1, 16'd0);
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 chk_out_cleared("async_reset");
      chk("async_reset_ready0", bus.req0_ready, 1'b0);
      chk("async_reset_ready1", bus.req1_ready, 1'b0);
      q.delete();
      last_g = 1'b1;
      cnt0   = 0;
      cnt1   = 0;
   endtask

   task automatic rnd_inputs();
      bus.req0_valid = ($urandom_range(0, 9) < 7);
      bus.req1_valid = ($urandom_range(0, 9) < 7);
      bus.req0_data  = rnd_data();
      bus.req1_data  = rnd_data();
      bus.out_ready  = ($urandom_range(0, 9) < 6);
   endtask

   initial begin
      logic [3:0] seq;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_data  = '0;
      bus.out_ready  = 1'b0;
      cyc = 0; last_g = 1'b1; cnt0 = 0; cnt1 = 0;
      vectors = 0; miscompares = 0; obs_acc = 0; obs_r1 = 1'b0;

      // Reset state, with both requesters asking
      repeat (2) @(posedge clk);
      #1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      chk_out_cleared("reset");
      chk("reset_ready0", bus.req0_ready, 1'b0);
      chk("reset_ready1", bus.req1_ready, 1'b0);
      chk("reset_dec_in", bus.dec_in, '0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst_n = 1'b1;

      // Single word
      bus.out_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 64'h4000_0000_0000_0000;
      step();
      bus.req0_valid = 1'b0;
      repeat (4) step();

      // Contention right after reset: grants alternate 0,1,0,1
      do_reset();
      step();
      rst_n = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      seq = '0;
      for (int i = 0; i < 4; i++) begin
         bus.req0_data = {$urandom, $urandom};
         bus.req1_data = {$urandom, $urandom};
         step();
         seq = {seq[2:0], obs_r1};
      end
      chk("grant_alternation", seq, 4'b0101);
      chk("contention_cnt0", bus.grant_cnt0, 16'd2);
      chk("contention_cnt1", bus.grant_cnt1, 16'd2);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (3) step();

      // Zero then NaR from req1, then a negative word from req0
      bus.req1_valid = 1'b1;
      bus.req1_data  = '0;
      step();
      bus.req1_data  = Nar;
      step();
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 64'hC000_0000_0000_0000;
      step();
      bus.req0_valid = 1'b0;
      repeat (4) step();

      // Backpressure: only the two pipeline slots fill
      bus.out_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      obs_acc = 0;
      for (int i = 0; i < 5; i++) begin
         bus.req0_data = {$urandom, $urandom};
         step();
      end
      chk("stall_accepts", obs_acc, 2);
      bus.req0_valid = 1'b0;
      bus.out_ready  = 1'b1;
      repeat (4) step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rnd_inputs();
         step();
      end

      // Reset with both stages full, then traffic again
      bus.out_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b0;
      repeat (3) step();
      do_reset();
      bus.req1_valid = 1'b1;
      bus.out_ready  = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 100; i++) begin
         rnd_inputs();
         step();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.out_ready  = 1'b1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/posit_decode_sched.md
POSIT_DECODE_SCHED -- requirements
Module: posit_decode_sched

Interface
REQ-001 SHALL have parameter N, default 64: posit width.
REQ-002 SHALL have parameter ES, default 4: exponent field width.
REQ-003 SHALL have parameter RS, default 7: regime output width.
REQ-004 SHALL have parameter FS, default N-ES-3: fraction output width.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports req0_valid/req1_valid, input, 1 each: requester has a posit.
REQ-008 SHALL have ports req0_data/req1_data, input, N each: posit word.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1 each: word accepted this cycle.
REQ-010 SHALL have port dec_in, output, N-1: magnitude bits driven to the shared combinational decode core.
REQ-011 SHALL have ports dec_regi (RS), dec_expo (ES) and dec_frac (FS), all inputs: core results for the current dec_in.
REQ-012 SHALL have port out_valid, output, 1, and port out_ready, input, 1: result handshake.
REQ-013 SHALL have port out_tag, output, 1: requester index of the result.
REQ-014 SHALL have ports out_sign, out_zero and out_nar, outputs, 1 each: result flags.
REQ-015 SHALL have ports out_regi (RS), out_expo (ES) and out_frac (FS), all outputs: decoded fields.
REQ-016 SHALL have ports grant_cnt0/grant_cnt1, output, 16 each: accepted-word counters.

Function
REQ-017 SHALL implement a 2-stage pipeline: S1 holds magnitude, sign, flags and tag; S2 is the output register.
- Each stage has its own valid bit.
REQ-018 SHALL drive dec_in combinationally from the S1 magnitude bits [N-2:0].
- dec_in SHALL be 0 when S1 is empty.
REQ-019 SHALL capture dec_* results into S2 on the same edge that S1 advances.
REQ-020 SHALL advance S1 when S1 is valid and (S2 is empty or out_ready=1).
REQ-021 SHALL accept into S1 when S1 is empty or S1 advances in that cycle.
REQ-022 SHALL give a latency of 2 cycles from the acceptance edge to out_valid=1.
- Throughput SHALL be 1 word/cycle while out_ready=1.
REQ-023 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-024 SHALL arbitrate round-robin using register last_grant.
- A requester is granted if it is the only one with valid=1.
- If both are valid, the one not equal to last_grant is granted.
- last_grant updates only on acceptance.
REQ-025 SHALL assert at most one reqX_ready per cycle.
- reqX_ready = grantX AND accept-condition.
- reqX_ready SHALL be 0 when reqX_valid=0.
REQ-026 SHALL set sign = data[N-1] on acceptance.
- Stored magnitude = data when sign=0, two's complement of data (N-bit) when sign=1.
REQ-027 SHALL set zero=1 when data is all zeros, and nar=1 when data = 1 followed by N-1 zeros.
- In either case, out_regi, out_expo, out_frac and out_sign SHALL be 0 regardless of dec_*.
REQ-028 SHALL increment grant_cnt0/grant_cnt1 on each acceptance from the corresponding requester.
- Counters SHALL saturate at 16'hFFFF.
REQ-029 SHALL leave requester data unregistered until acceptance; no internal buffering beyond S1/S2.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear S1/S2 valid bits and all out_* to 0, set last_grant=1, and clear both counters.
REQ-031 SHALL hold reqX_ready=0 while rst_n=0.
REQ-032 SHALL discard any in-flight words when reset is asserted mid-operation.
- The first acceptance after release SHALL go to req0 if req0 is valid.

Verification
REQ-033 Single word: req0 data=64'h4000_0000_0000_0000 with out_ready=1 -> req0_ready=1 in cycle 0; dec_in=63'h4000_0000_0000_0000 in cycle 1; out_valid=1, out_tag=0, out_sign=0 in cycle 2; out_* equal the dec_* sampled in cycle 1.
REQ-034 Contention: both requesters valid for 4 cycles after reset -> grants alternate 0,1,0,1; grant_cnt0=2, grant_cnt1=2.
REQ-035 Special values: req1 data=0 then 64'h8000_0000_0000_0000 -> results with out_zero=1 then out_nar=1; regi/expo/frac=0 in both.
REQ-036 Negative input: data=64'hC000_0000_0000_0000 -> dec_in=63'h4000_0000_0000_0000 and out_sign=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles with continuous req0 traffic -> exactly 2 words accepted; out_* stable; on out_ready=1 both drain in order with no loss or duplication.
REQ-038 Reset mid-stream: rst_n=0 while S1 and S2 are full -> out_valid=0 immediately; counters=0; no stale result after release.
